sb_transaction_parser: RTL and testbench
========================================

SB_TRANSACTION_PARSER -- requirements
Module: sb_transaction_parser

Interface
REQ-001 SHALL have parameter MAX_DATA, default 8, maximum data bytes per AT transaction (1..64).
REQ-002 SHALL have parameter LEN_W, default 7, width of the length field.
REQ-003 SHALL have port sb_clk  input  1  sideband clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sbrx  input  10  received symbol; byte at [8:1].
REQ-006 SHALL have port sbrx_valid  input  1  sbrx holds a new symbol this cycle.
REQ-007 SHALL have port error  input  1  symbol/framing error from receiver.
REQ-008 SHALL have port tconnect  input  1  link connected.
REQ-009 SHALL have port tdisconnect  input  1  link disconnected.
REQ-010 SHALL have port t_valid  output  1  one-cycle pulse: good transaction.
REQ-011 SHALL have port trans_error  output  1  one-cycle pulse: transaction dropped.
REQ-012 SHALL have port err_code  output  2  1=symbol error, 2=CRC mismatch, 3=length/framing; held until next error.
REQ-013 SHALL have port s_read / s_write  output  1 each  read/write command, qualified by t_valid.
REQ-014 SHALL have port s_response  output  1  transaction was a response (STX=0x04).
REQ-015 SHALL have port s_address  output  8  register address.
REQ-016 SHALL have port s_len  output  LEN_W  data byte count.
REQ-017 SHALL have port payload  output  8*MAX_DATA  data, byte i at [8i+7:8i], unused bytes zero.
REQ-018 SHALL have port disconnect  output  1  link in disconnected/LT-fall state.

Function
REQ-019 SHALL consume a symbol only in cycles where sbrx_valid=1; other cycles hold state.
REQ-020 SHALL use constants DLE=0xFE, STX_CMD=0x05, STX_RSP=0x04, ETX=0x40, LSE=0xA0, CLSE=0x5F.
REQ-021 SHALL implement states DISCONNECT, IDLE, SOF_DLE, BODY, BODY_DLE, LT, FALL.
REQ-022 DISCONNECT->IDLE on tconnect; any state->DISCONNECT on tdisconnect (highest priority, no pulses).
REQ-023 IDLE: DLE->SOF_DLE; other bytes ignored.
REQ-024 SOF_DLE: STX_CMD/STX_RSP->BODY (STX enters CRC), LSE->LT, DLE->SOF_DLE, else->IDLE.
REQ-025 LT: CLSE->FALL; DLE->SOF_DLE; else stay. FALL exits only via tdisconnect.
REQ-026 Frame body SHALL be: address, {wnr[7], len[6:0]}, len data bytes (write cmd or read rsp only), CRC low, CRC high.
REQ-027 BODY: DLE->BODY_DLE; other byte stored at body index, index+1.
REQ-028 BODY_DLE: DLE->store one 0xFE data byte (unstuff), ->BODY; ETX->frame end check; any other->error.
REQ-029 CRC SHALL be CRC-16 poly 0x8005, init 0xFFFF, over STX through last data byte, computed one byte per consumed symbol.
REQ-030 At ETX: pulse t_valid one cycle later iff CRC matches, len<=MAX_DATA and byte count = 4+expected data count; else trans_error code 2 or 3.
REQ-031 Body byte count exceeding 4+MAX_DATA SHALL raise trans_error code 3 immediately and return to IDLE.
REQ-032 error=1 in SOF_DLE/BODY/BODY_DLE SHALL abort: trans_error code 1 next cycle, ->IDLE; in IDLE/LT ignored.
REQ-033 s_write=wnr&~response, s_read=~wnr&~response; s_* and payload update only with t_valid and hold otherwise.
REQ-034 t_valid and trans_error SHALL never assert in the same cycle.

Reset
REQ-035 On rst low: state DISCONNECT, disconnect=1, all other outputs, counters, payload zero, CRC register 0xFFFF.
REQ-036 Reset mid-frame SHALL discard the frame with no pulse.

Structure
REQ-037 Symbol constants, state enum and err_code encodings SHALL reside in shared package sb_pkg.
REQ-038 CRC SHALL be sub-module sb_crc16 (init, byte_en, byte, crc out); parser FSM in top.

Verification
REQ-039 Write: DLE 05 10 83 AA FE FE 55 CRC DLE 40 -> t_valid, s_write=1, s_address=0x10, s_len=3, payload low bytes 55_FE_AA.
REQ-040 Same frame with CRC low byte flipped -> trans_error, err_code=2, no t_valid, outputs unchanged.
REQ-041 MAX_DATA=8, write len=9 -> trans_error code 3 at 13th body byte, state IDLE.
REQ-042 error pulsed mid-BODY, then valid read DLE 05 20 00 CRC DLE 40 -> code 1, then t_valid with s_read=1, s_address=0x20.
REQ-043 DLE LSE CLSE -> disconnect=1 held; tdisconnect, tconnect -> IDLE, disconnect=0.
REQ-044 sbrx_valid low for 3 cycles between every symbol of REQ-039 frame -> identical result.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared sideband definitions: framing symbols, parser states, error codes, CRC step.
package sb_pkg;

  // Framing symbols
  localparam logic [7:0] SymDle    = 8'hFE;
  localparam logic [7:0] SymStxCmd = 8'h05;
  localparam logic [7:0] SymStxRsp = 8'h04;
  localparam logic [7:0] SymEtx    = 8'h40;
  localparam logic [7:0] SymLse    = 8'hA0;
  localparam logic [7:0] SymClse   = 8'h5F;

  // CRC-16 parameters
  localparam logic [15:0] CrcPoly = 16'h8005;
  localparam logic [15:0] CrcInit = 16'hFFFF;

  typedef enum logic [2:0] {
    StDisconnect,
    StIdle,
    StSofDle,
    StBody,
    StBodyDle,
    StLt,
    StFall
  } sb_state_e;

  typedef enum logic [1:0] {
    ErrNone   = 2'd0,
    ErrSymbol = 2'd1,
    ErrCrc    = 2'd2,
    ErrFrame  = 2'd3
  } sb_err_e;

  // One byte of CRC-16, MSB first, no reflection.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CrcPoly;
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_crc16.sv
// CRC-16 (poly 0x8005) accumulator, one byte per enabled cycle.
module sb_crc16
  import sb_pkg::*;
(
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        init,
  input  logic        byte_en,
  input  logic [7:0]  in_byte,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic [15:0] base;

  // init restarts from the seed; with byte_en the seed absorbs the byte the same cycle
  always_comb begin
    base  = init ? CrcInit : crc_q;
    crc_d = crc_q;
    if (byte_en) begin
      crc_d = crc16_update(base, in_byte);
    end else if (init) begin
      crc_d = CrcInit;
    end
  end

  // CRC register
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      crc_q <= CrcInit;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sb_transaction_parser.sv
// Sideband transaction parser: DLE-framed symbol stream to decoded register transactions.
module sb_transaction_parser
  import sb_pkg::*;
#(
  parameter int unsigned MAX_DATA = 8,
  parameter int unsigned LEN_W    = 7
) (
  input  logic                  sb_clk,
  input  logic                  rst,
  input  logic [9:0]            sbrx,
  input  logic                  sbrx_valid,
  input  logic                  error,
  input  logic                  tconnect,
  input  logic                  tdisconnect,
  output logic                  t_valid,
  output logic                  trans_error,
  output logic [1:0]            err_code,
  output logic                  s_read,
  output logic                  s_write,
  output logic                  s_response,
  output logic [7:0]            s_address,
  output logic [LEN_W-1:0]      s_len,
  output logic [8*MAX_DATA-1:0] payload,
  output logic                  disconnect
);

  localparam int unsigned PayW    = 8 * MAX_DATA;
  localparam logic [7:0]  BodyMax = 8'(4 + MAX_DATA);
  localparam logic [7:0]  DataMax = 8'(MAX_DATA);

  sb_state_e        state_q;
  logic [7:0]       idx_q;
  logic [7:0]       addr_q;
  logic             wnr_q;
  logic [6:0]       len_q;
  logic             rsp_q;
  logic [7:0]       b0_q, b1_q;   // last and second-to-last body bytes (CRC high, low at ETX)
  logic [PayW-1:0]  stage_q;

  logic [7:0]  rx_byte;
  logic        in_frame;
  logic        consume;
  logic        is_stx;
  logic        data_present;
  logic [7:0]  exp_cnt;
  logic [7:0]  data_slot;
  logic        store_en;
  logic        overflow;
  logic        data_wr;
  logic        cnt_ok;
  logic        crc_ok;
  logic        crc_init;
  logic        crc_en;
  logic [15:0] crc;
  logic        unused_sym_bits;

  assign rx_byte         = sbrx[8:1];
  assign unused_sym_bits = sbrx[9] ^ sbrx[0];

  // Decode of the current symbol against the frame context
  always_comb begin
    in_frame     = (state_q == StSofDle) || (state_q == StBody) || (state_q == StBodyDle);
    consume      = sbrx_valid && !tdisconnect && !(error && in_frame);
    is_stx       = (rx_byte == SymStxCmd) || (rx_byte == SymStxRsp);
    // Data follows only on write commands and read responses
    data_present = rsp_q ? !wnr_q : wnr_q;
    exp_cnt      = data_present ? {1'b0, len_q} : 8'd0;
    data_slot    = idx_q - 8'd2;
    store_en     = consume && (((state_q == StBody) && (rx_byte != SymDle)) ||
                               ((state_q == StBodyDle) && (rx_byte == SymDle)));
    overflow     = idx_q >= BodyMax;
    data_wr      = store_en && !overflow && (idx_q >= 8'd2) && (data_slot < exp_cnt) &&
                   (data_slot < DataMax);
    cnt_ok       = ({1'b0, len_q} <= DataMax) && (idx_q == exp_cnt + 8'd4);
    crc_ok       = crc == {b0_q, b1_q};
    crc_init     = consume && (state_q == StSofDle) && is_stx;
    // Header and data bytes feed the CRC; trailing CRC bytes do not
    crc_en       = crc_init || (store_en && ((idx_q < 8'd2) || (data_slot < exp_cnt)));
  end

  sb_crc16 u_crc (
    .sb_clk  (sb_clk),
    .rst     (rst),
    .init    (crc_init),
    .byte_en (crc_en),
    .in_byte (rx_byte),
    .crc     (crc)
  );

  // Parser FSM with registered outputs
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StDisconnect;
      idx_q       <= '0;
      addr_q      <= '0;
      wnr_q       <= 1'b0;
      len_q       <= '0;
      rsp_q       <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      stage_q     <= '0;
      t_valid     <= 1'b0;
      trans_error <= 1'b0;
      err_code    <= ErrNone;
      s_read      <= 1'b0;
      s_write     <= 1'b0;
      s_response  <= 1'b0;
      s_address   <= '0;
      s_len       <= '0;
      payload     <= '0;
      disconnect  <= 1'b1;
    end else begin
      t_valid     <= 1'b0;
      trans_error <= 1'b0;
      if (tdisconnect) begin
        state_q    <= StDisconnect;
        disconnect <= 1'b1;
      end else if (error && in_frame) begin
        trans_error <= 1'b1;
        err_code    <= ErrSymbol;
        state_q     <= StIdle;
      end else begin
        case (state_q)
          StDisconnect: begin
            if (tconnect) begin
              state_q    <= StIdle;
              disconnect <= 1'b0;
            end
          end
          StIdle: begin
            if (consume && (rx_byte == SymDle)) state_q <= StSofDle;
          end
          StSofDle: begin
            if (consume) begin
              if (is_stx) begin
                state_q <= StBody;
                rsp_q   <= (rx_byte == SymStxRsp);
                idx_q   <= '0;
                addr_q  <= '0;
                wnr_q   <= 1'b0;
                len_q   <= '0;
                stage_q <= '0;
              end else if (rx_byte == SymLse) begin
                state_q <= StLt;
              end else if (rx_byte != SymDle) begin
                state_q <= StIdle;
              end
            end
          end
          StBody: begin
            if (consume && (rx_byte == SymDle)) state_q <= StBodyDle;
          end
          StBodyDle: begin
            if (consume) begin
              if (rx_byte == SymDle) begin
                state_q <= StBody;
              end else if (rx_byte == SymEtx) begin
                state_q <= StIdle;
                if (cnt_ok && crc_ok) begin
                  t_valid    <= 1'b1;
                  s_address  <= addr_q;
                  s_len      <= LEN_W'(len_q);
                  s_write    <= wnr_q & ~rsp_q;
                  s_read     <= ~wnr_q & ~rsp_q;
                  s_response <= rsp_q;
                  payload    <= stage_q;
                end else begin
                  trans_error <= 1'b1;
                  err_code    <= cnt_ok ? ErrCrc : ErrFrame;
                end
              end else begin
                trans_error <= 1'b1;
                err_code    <= ErrFrame;
                state_q     <= StIdle;
              end
            end
          end
          StLt: begin
            if (consume) begin
              if (rx_byte == SymClse) begin
                state_q    <= StFall;
                disconnect <= 1'b1;
              end else if (rx_byte == SymDle) begin
                state_q <= StSofDle;
              end
            end
          end
          StFall: begin
            state_q <= StFall;
          end
          default: begin
            state_q    <= StDisconnect;
            disconnect <= 1'b1;
          end
        endcase

        if (store_en) begin
          if (overflow) begin
            trans_error <= 1'b1;
            err_code    <= ErrFrame;
            state_q     <= StIdle;
          end else begin
            idx_q <= idx_q + 8'd1;
            b1_q  <= b0_q;
            b0_q  <= rx_byte;
            if (idx_q == 8'd0) addr_q <= rx_byte;
            if (idx_q == 8'd1) {wnr_q, len_q} <= rx_byte;
            for (int unsigned i = 0; i < MAX_DATA; i++) begin
              if (data_wr && (data_slot == 8'(i))) stage_q[8*i +: 8] <= rx_byte;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sb_transaction_parser.sv
// Scoreboard bench for sb_transaction_parser.
module tb_sb_transaction_parser;

  localparam int unsigned MaxData = 8;
  localparam int unsigned LenW    = 7;

  localparam logic [7:0] Dle  = 8'hFE;
  localparam logic [7:0] Etx  = 8'h40;
  localparam logic [7:0] Lse  = 8'hA0;
  localparam logic [7:0] Clse = 8'h5F;

  logic                 sb_clk;
  logic                 rst;
  logic [9:0]           sbrx;
  logic                 sbrx_valid;
  logic                 error;
  logic                 tconnect;
  logic                 tdisconnect;
  logic                 t_valid;
  logic                 trans_error;
  logic [1:0]           err_code;
  logic                 s_read;
  logic                 s_write;
  logic                 s_response;
  logic [7:0]           s_address;
  logic [LenW-1:0]      s_len;
  logic [8*MaxData-1:0] payload;
  logic                 disconnect;

  sb_transaction_parser #(
    .MAX_DATA (MaxData),
    .LEN_W    (LenW)
  ) dut (
    .sb_clk      (sb_clk),
    .rst         (rst),
    .sbrx        (sbrx),
    .sbrx_valid  (sbrx_valid),
    .error       (error),
    .tconnect    (tconnect),
    .tdisconnect (tdisconnect),
    .t_valid     (t_valid),
    .trans_error (trans_error),
    .err_code    (err_code),
    .s_read      (s_read),
    .s_write     (s_write),
    .s_response  (s_response),
    .s_address   (s_address),
    .s_len       (s_len),
    .payload     (payload),
    .disconnect  (disconnect)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic        rd;
    logic        wr;
    logic        rsp;
    logic [7:0]  addr;
    logic [6:0]  len;
    logic [63:0] pay;
  } exp_t;

  exp_t sb_q[$];

  // Model of the held transaction outputs
  logic        h_rd, h_wr, h_rsp;
  logic [7:0]  h_addr;
  logic [6:0]  h_len;
  logic [63:0] h_pay;
  logic [1:0]  h_code;

  logic [7:0] body_q[$];
  int         gap = 0;

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] frame_crc(input logic [7:0] stx);
    logic [15:0] c;
    c = crc_model(16'hFFFF, stx);
    foreach (body_q[k]) c = crc_model(c, body_q[k]);
    return c;
  endfunction

  function automatic exp_t held_rec();
    exp_t e;
    e.is_err = 1'b0; e.code = h_code;
    e.rd = h_rd; e.wr = h_wr; e.rsp = h_rsp;
    e.addr = h_addr; e.len = h_len; e.pay = h_pay;
    return e;
  endfunction

  task automatic expect_good(input logic [7:0] stx);
    logic wnr;
    wnr    = body_q[0+1][7];
    h_rsp  = (stx == 8'h04);
    h_wr   = wnr && !h_rsp;
    h_rd   = !wnr && !h_rsp;
    h_addr = body_q[0];
    h_len  = body_q[1][6:0];
    h_pay  = '0;
    for (int k = 2; k < body_q.size(); k++) h_pay[8*(k-2) +: 8] = body_q[k];
    sb_q.push_back(held_rec());
  endtask

  task automatic expect_err(input logic [1:0] code);
    exp_t e;
    h_code   = code;
    e        = held_rec();
    e.is_err = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge sb_clk); #1; end
  endtask

  task automatic sym(input logic [7:0] b);
    sbrx       = {1'b0, b, 1'b0};
    sbrx_valid = 1'b1;
    @(posedge sb_clk); #1;
    sbrx_valid = 1'b0;
    repeat (gap) begin @(posedge sb_clk); #1; end
  endtask

  task automatic put(input logic [7:0] b);
    sym(b);
    if (b == Dle) sym(Dle);
  endtask

  task automatic send_frame(input logic [7:0] stx, input logic [15:0] flip);
    logic [15:0] c;
    c = frame_crc(stx) ^ flip;
    sym(Dle);
    sym(stx);
    foreach (body_q[k]) put(body_q[k]);
    put(c[7:0]);
    put(c[15:8]);
    sym(Dle);
    sym(Etx);
  endtask

  task automatic pulse_connect();
    tconnect = 1'b1; @(posedge sb_clk); #1; tconnect = 1'b0;
  endtask

  task automatic pulse_disconnect();
    tdisconnect = 1'b1; @(posedge sb_clk); #1; tdisconnect = 1'b0;
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue
  always @(negedge sb_clk) begin : mon
    exp_t e;
    if (rst && (t_valid || trans_error)) begin
      check_eq("pulse_excl", 64'(t_valid & trans_error), 0);
      if (sb_q.size() == 0) begin
        check_eq("unexp_pulse", 64'({t_valid, trans_error}), 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("pulse_kind", 64'({t_valid, trans_error}), e.is_err ? 64'd1 : 64'd2);
        if (e.is_err) check_eq("err_code", 64'(err_code), 64'(e.code));
        check_eq("s_read", 64'(s_read), 64'(e.rd));
        check_eq("s_write", 64'(s_write), 64'(e.wr));
        check_eq("s_response", 64'(s_response), 64'(e.rsp));
        check_eq("s_address", 64'(s_address), 64'(e.addr));
        check_eq("s_len", 64'(s_len), 64'(e.len));
        check_eq("payload", 64'(payload), e.pay);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    rst = 1'b0; sbrx = '0; sbrx_valid = 1'b0; error = 1'b0;
    tconnect = 1'b0; tdisconnect = 1'b0;
    h_rd = 0; h_wr = 0; h_rsp = 0; h_addr = 0; h_len = 0; h_pay = 0; h_code = 0;
    idle(3);
    check_eq("rst_disconnect", 64'(disconnect), 1);
    check_eq("rst_t_valid", 64'(t_valid), 0);
    check_eq("rst_trans_error", 64'(trans_error), 0);
    check_eq("rst_err_code", 64'(err_code), 0);
    check_eq("rst_s_address", 64'(s_address), 0);
    check_eq("rst_s_len", 64'(s_len), 0);
    check_eq("rst_payload", 64'(payload), 0);
    check_eq("rst_s_write", 64'(s_write), 0);
    rst = 1'b1;
    idle(2);
    check_eq("wait_connect", 64'(disconnect), 1);
    pulse_connect();
    check_eq("connected", 64'(disconnect), 0);

    // Write with stuffed data byte
    body_q = '{8'h10, 8'h83, 8'hAA, 8'hFE, 8'h55};
    expect_good(8'h05);
    send_frame(8'h05, 16'h0000);
    idle(3);
    check_eq("w_write", 64'(s_write), 1);
    check_eq("w_addr", 64'(s_address), 64'h10);
    check_eq("w_len", 64'(s_len), 3);
    check_eq("w_payload", 64'(payload), 64'h55FEAA);

    // Same frame, CRC low byte corrupted
    expect_err(2'd2);
    send_frame(8'h05, 16'h0001);
    idle(3);
    check_eq("crc_err_hold_addr", 64'(s_address), 64'h10);

    // Read response carrying data
    body_q = '{8'h33, 8'h02, 8'h11, 8'h22};
    expect_good(8'h04);
    send_frame(8'h04, 16'h0000);
    idle(3);
    check_eq("err_code_held", 64'(err_code), 2);

    // Length field disagrees with byte count
    body_q = '{8'h40, 8'h82, 8'h01, 8'h02, 8'h03};
    expect_err(2'd3);
    send_frame(8'h05, 16'h0000);
    idle(3);

    // len=9 exceeds MAX_DATA: error at the 13th body byte
    body_q = '{8'h10, 8'h89, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    expect_err(2'd3);
    c = frame_crc(8'h05);
    sym(Dle); sym(8'h05);
    foreach (body_q[k]) put(body_q[k]);
    put(c[7:0]);
    check_eq("ovf_early", 64'(trans_error), 0);
    put(c[15:8]);
    check_eq("ovf_now", 64'(trans_error), 1);
    sym(Dle); sym(Etx);
    idle(3);

    // Bad byte after DLE inside body
    expect_err(2'd3);
    sym(Dle); sym(8'h05); sym(8'h10); sym(Dle); sym(8'h33);
    idle(3);

    // Symbol error mid-body, then a clean read
    expect_err(2'd1);
    sym(Dle); sym(8'h05); sym(8'h10); sym(8'h83); sym(8'hAA);
    error = 1'b1; @(posedge sb_clk); #1; error = 1'b0;
    idle(2);
    body_q = '{8'h20, 8'h00};
    expect_good(8'h05);
    send_frame(8'h05, 16'h0000);
    idle(3);
    check_eq("r_read", 64'(s_read), 1);
    check_eq("r_addr", 64'(s_address), 64'h20);
    check_eq("r_payload", 64'(payload), 0);

    // Write frame with idle gaps between every symbol
    gap = 3;
    body_q = '{8'h10, 8'h83, 8'hAA, 8'hFE, 8'h55};
    expect_good(8'h05);
    send_frame(8'h05, 16'h0000);
    gap = 0;
    idle(4);
    check_eq("gap_payload", 64'(payload), 64'h55FEAA);
    check_eq("gap_write", 64'(s_write), 1);

    // tdisconnect mid-frame: no pulse, everything ignored until reconnect
    sym(Dle); sym(8'h05); sym(8'h10);
    pulse_disconnect();
    check_eq("tdisc_mid", 64'(disconnect), 1);
    send_frame(8'h05, 16'h0000);
    idle(3);
    pulse_connect();
    check_eq("reconnect", 64'(disconnect), 0);

    // Link training fall
    sym(Dle); sym(Lse); sym(Clse);
    check_eq("fall_disc", 64'(disconnect), 1);
    send_frame(8'h05, 16'h0000);
    idle(3);
    check_eq("fall_hold", 64'(disconnect), 1);
    pulse_disconnect();
    pulse_connect();
    check_eq("fall_exit", 64'(disconnect), 0);
    body_q = '{8'h33, 8'h02, 8'h11, 8'h22};
    expect_good(8'h04);
    send_frame(8'h04, 16'h0000);
    idle(3);
    check_eq("rsp_flag", 64'(s_response), 1);

    // Reset mid-frame discards everything
    sym(Dle); sym(8'h05); sym(8'h10); sym(8'h83);
    rst = 1'b0; #1;
    h_rd = 0; h_wr = 0; h_rsp = 0; h_addr = 0; h_len = 0; h_pay = 0; h_code = 0;
    check_eq("mid_rst_disc", 64'(disconnect), 1);
    check_eq("mid_rst_addr", 64'(s_address), 0);
    check_eq("mid_rst_payload", 64'(payload), 0);
    @(posedge sb_clk); #1;
    rst = 1'b1;
    idle(3);
    pulse_connect();
    body_q = '{8'h10, 8'h83, 8'hAA, 8'hFE, 8'h55};
    expect_good(8'h05);
    send_frame(8'h05, 16'h0000);
    idle(10);

    check_eq("sb_drained", 64'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
